// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready initiator for a 1024x10 RAM (paired async read, word sync write).
// Optional RAM_ACCESS_SIGN_EXT_EN: sign-extend RD_WORD results instead of zero-extending. Rev 1.0
`default_nettype none

module ram_access_ctrl #(
  parameter int AW = 10,
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [AW-1:0]   req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic            resp_valid,
  output logic [2*DW-1:0] resp_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [2*DW-1:0] mem_rdata
);

  localparam logic [1:0] OP_RD_WORD = 2'b00;
  localparam logic [1:0] OP_RD_PAIR = 2'b01;
  localparam logic [1:0] OP_WR_WORD = 2'b10;
  localparam logic [1:0] OP_WR_PAIR = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_WR2  = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [2*DW-1:0] wdata_q;

  logic            accept;
  logic            unaligned_pair;
  logic [AW-1:0]   addr_inc;
  logic [DW-1:0]   word_sel;
  logic [2*DW-1:0] word_ext;

  assign accept         = req_valid & req_ready;
  assign unaligned_pair = (op_q == OP_RD_PAIR) & addr_q[0];
  assign addr_inc       = addr_q + AW'(1);  // wraps modulo 2^AW
  assign word_sel       = addr_q[0] ? mem_rdata[2*DW-1:DW] : mem_rdata[DW-1:0];

`ifdef RAM_ACCESS_SIGN_EXT_EN
  assign word_ext = {{DW{word_sel[DW-1]}}, word_sel};
`else
  assign word_ext = {{DW{1'b0}}, word_sel};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_valid) state_nx = req_op[1] ? S_WR1 : S_RD1;
      S_RD1:  state_nx = unaligned_pair ? S_RD2 : S_RESP;
      S_RD2:  state_nx = S_RESP;
      S_WR1:  state_nx = (op_q == OP_WR_PAIR) ? S_WR2 : S_RESP;
      S_WR2:  state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_RD_WORD;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            mem_addr <= req_addr;
            if (req_op[1]) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata[DW-1:0];
            end
          end
        end
        S_RD1: begin
          if (op_q == OP_RD_WORD) begin
            resp_rdata <= word_ext;
          end else if (unaligned_pair) begin
            // Odd address: ram[addr] is the upper half of this pair, ram[addr+1] the lower of the next.
            resp_rdata[DW-1:0] <= mem_rdata[2*DW-1:DW];
            mem_addr           <= addr_inc;
          end else begin
            resp_rdata <= mem_rdata;
          end
        end
        S_RD2: resp_rdata[2*DW-1:DW] <= mem_rdata[DW-1:0];
        S_WR1: begin
          if (op_q == OP_WR_PAIR) begin
            mem_addr  <= addr_inc;
            mem_wdata <= wdata_q[2*DW-1:DW];
          end else begin
            mem_we <= 1'b0;
          end
        end
        S_WR2: mem_we <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed self-checking bench with a behavioural 1024x10 paired-read RAM.
`default_nettype none

module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [9:0]  req_addr;
  logic [19:0] req_wdata;
  logic        resp_valid;
  logic [19:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [9:0]  mem_wdata;
  logic [19:0] mem_rdata;

  logic [9:0] ram [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = {ram[{mem_addr[9:1], 1'b1}], ram[{mem_addr[9:1], 1'b0}]};

  ram_access_ctrl #(.AW(10), .DW(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Issues one request and observes 8 cycles: latency (0 = never answered), data, write cycles, first two addresses.
  task automatic do_req(input logic [1:0] op, input logic [9:0] a, input logic [19:0] wd,
                        output int lat, output logic [19:0] rd, output int wec, output int rvc,
                        output logic [9:0] ma1, output logic [9:0] ma2);
    lat = 0; wec = 0; rvc = 0; rd = '0; ma1 = '0; ma2 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) ma1 = mem_addr;
      if (n == 2) ma2 = mem_addr;
      if (mem_we) wec++;
      if (resp_valid) begin
        rvc++;
        if (lat == 0) begin lat = n; rd = resp_rdata; end
      end
    end
  endtask

  task automatic test_reset();
    ram[5] = 10'h000;
    reset = 1'b1; req_valid = 1'b1; req_op = 2'b10; req_addr = 10'd5; req_wdata = 20'h003FF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata} !== 42'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d: we=%b addr=%h wdata=%h rv=%b rd=%h, required all 0",
                 c, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata);
      end
    end
    req_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    total++;
    if (ram[5] !== 10'h000) begin bad++; $display("FAIL reset_no_write: ram[5]=%h required 000", ram[5]); end
  endtask

  task automatic test_wr_word_rd_pair();
    int lat, wec, rvc; logic [19:0] rd; logic [9:0] m1, m2;
    do_req(2'b10, 10'd10, 20'h00005, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 2 || wec !== 1 || rvc !== 1) begin bad++; $display("FAIL wr_word10: lat=%0d we=%0d rv=%0d required 2/1/1", lat, wec, rvc); end
    do_req(2'b10, 10'd11, 20'h00003, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 2 || wec !== 1 || rvc !== 1) begin bad++; $display("FAIL wr_word11: lat=%0d we=%0d rv=%0d required 2/1/1", lat, wec, rvc); end
    total++;
    if (ram[10] !== 10'h005 || ram[11] !== 10'h003) begin bad++; $display("FAIL wr_word_ram: ram10=%h ram11=%h required 005/003", ram[10], ram[11]); end
    do_req(2'b01, 10'd10, 20'h0, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 2 || rd !== 20'h00C05 || wec !== 0) begin bad++; $display("FAIL rd_pair10: lat=%0d rd=%h we=%0d required 2/00c05/0", lat, rd, wec); end
  endtask

  task automatic test_rd_word_unaligned();
    int lat, wec, rvc; logic [19:0] rd; logic [9:0] m1, m2;
    do_req(2'b00, 10'd11, 20'h0, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 2 || rd !== 20'h00003) begin bad++; $display("FAIL rd_word11: lat=%0d rd=%h required 2/00003", lat, rd); end
    do_req(2'b00, 10'd10, 20'h0, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 2 || rd !== 20'h00005) begin bad++; $display("FAIL rd_word10: lat=%0d rd=%h required 2/00005", lat, rd); end
    @(negedge clk) ram[12] = 10'h000;
    do_req(2'b01, 10'd11, 20'h0, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 3 || rd !== 20'h00003 || rvc !== 1) begin bad++; $display("FAIL rd_pair11: lat=%0d rd=%h rv=%0d required 3/00003/1", lat, rd, rvc); end
    total++;
    if (m1 !== 10'd11 || m2 !== 10'd12) begin bad++; $display("FAIL rd_pair11_addr: %0d,%0d required 11,12", m1, m2); end
  endtask

  task automatic test_wrap();
    int lat, wec, rvc; logic [19:0] rd; logic [9:0] m1, m2;
    @(negedge clk); ram[1023] = 10'h3FF; ram[0] = 10'h00A;
    do_req(2'b01, 10'd1023, 20'h0, lat, rd, wec, rvc, m1, m2);
    total++;
    if (m1 !== 10'd1023 || m2 !== 10'd0) begin bad++; $display("FAIL wrap_addr: %0d,%0d required 1023,0", m1, m2); end
    total++;
    if (lat !== 3 || rd !== 20'h02BFF) begin bad++; $display("FAIL wrap_data: lat=%0d rd=%h required 3/02bff", lat, rd); end
  endtask

  task automatic test_wr_pair();
    int lat, wec, rvc; logic [19:0] rd; logic [9:0] m1, m2;
    do_req(2'b11, 10'd51, 20'h2A155, lat, rd, wec, rvc, m1, m2);
    total++;
    if (ram[51] !== 10'h155 || ram[52] !== 10'h0A8) begin bad++; $display("FAIL wr_pair_ram: %h,%h required 155,0a8", ram[51], ram[52]); end
    total++;
    if (lat !== 3 || wec !== 2 || rvc !== 1) begin bad++; $display("FAIL wr_pair_timing: lat=%0d we=%0d rv=%0d required 3/2/1", lat, wec, rvc); end
    total++;
    if (rd !== 20'h02BFF) begin bad++; $display("FAIL wr_pair_hold_rdata: %h required 02bff", rd); end
  endtask

  task automatic test_reset_mid_write();
    int rvc = 0;
    @(negedge clk); ram[51] = 10'h000; ram[52] = 10'h111;
    req_valid = 1'b1; req_op = 2'b11; req_addr = 10'd51; req_wdata = 20'h2A155;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL abort_state: we=%b ready=%b required 0/1", mem_we, req_ready); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (resp_valid) rvc++;
    end
    total++;
    if (ram[51] !== 10'h155 || ram[52] !== 10'h111) begin bad++; $display("FAIL abort_ram: %h,%h required 155,111", ram[51], ram[52]); end
    total++;
    if (rvc !== 0) begin bad++; $display("FAIL abort_no_resp: %0d pulses required 0", rvc); end
  endtask

  task automatic test_sign_ext();
    int lat, wec, rvc; logic [19:0] rd; logic [9:0] m1, m2; logic [19:0] exp_rd;
`ifdef RAM_ACCESS_SIGN_EXT_EN
    exp_rd = 20'hFFFFB;
`else
    exp_rd = 20'h003FB;
`endif
    @(negedge clk) ram[10] = 10'h3FB;
    do_req(2'b00, 10'd10, 20'h0, lat, rd, wec, rvc, m1, m2);
    total++;
    if (lat !== 2 || rd !== exp_rd) begin bad++; $display("FAIL rd_word_ext: lat=%0d rd=%h required 2/%h", lat, rd, exp_rd); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 10'h000;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    test_reset();
    test_wr_word_rd_pair();
    test_rd_word_unaligned();
    test_wrap();
    test_wr_pair();
    test_reset_mid_write();
    test_sign_ext();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
